decode_stage: RTL and testbench

Second pipeline stage of the MIPS core. Registers each `pc`/`instr` pair produced by the fetch frontend and decodes it, reading operands from the register file with EX/MEM/WB forwarding. It resolves branch comparison operands and returns `prev`, `prev_pc`, `eq` and `vs` to the frontend, and drives the ID/EX pipeline register. It detects data hazards and asserts `stall`; core top uses `stall` to hold fetch.

---
 rtl/mips_pkg.sv | 69 ++++++
 rtl/decode_ctrl.sv | 93 +++++++++
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core types: ALU operations, decode selectors, opcode/funct encodings.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_LUI,
    ALU_LINK
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_SIGN,
    IMM_ZERO,
    IMM_LUI,
    IMM_SHAMT,
    IMM_LINK
  } imm_sel_t;

  typedef enum logic [1:0] {
    DEST_NONE,
    DEST_RD,
    DEST_RT,
    DEST_RA
  } dest_sel_t;

  typedef struct packed {
    alu_op_t   op;
    imm_sel_t  imm_sel;
    dest_sel_t dest_sel;
    logic      wr;
    logic      load;
    logic      store;
    logic      uses_rs;
    logic      uses_rt;
    logic      is_branch;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_SLT  = 6'd42;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder: opcode/funct to control bundle.
// Anything outside the supported subset falls through as a non-writing nop.
module decode_ctrl
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL: begin
            ctrl.op       = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            ctrl.imm_sel  = IMM_SHAMT;
            ctrl.dest_sel = DEST_RD;
            ctrl.wr       = 1'b1;
            ctrl.uses_rt  = 1'b1;
          end
          FN_JR: begin
            ctrl.uses_rs   = 1'b1;
            ctrl.is_branch = 1'b1;
          end
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
            case (funct)
              FN_ADDU: ctrl.op = ALU_ADD;
              FN_SUBU: ctrl.op = ALU_SUB;
              FN_AND:  ctrl.op = ALU_AND;
              FN_OR:   ctrl.op = ALU_OR;
              default: ctrl.op = ALU_SLT;
            endcase
            ctrl.dest_sel = DEST_RD;
            ctrl.wr       = 1'b1;
            ctrl.uses_rs  = 1'b1;
            ctrl.uses_rt  = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
        case (opcode)
          OP_ADDIU: ctrl.op = ALU_ADD;
          OP_SLTI:  ctrl.op = ALU_SLT;
          OP_ANDI:  ctrl.op = ALU_AND;
          default:  ctrl.op = ALU_OR;
        endcase
        ctrl.imm_sel  = (opcode == OP_ANDI || opcode == OP_ORI) ? IMM_ZERO : IMM_SIGN;
        ctrl.dest_sel = DEST_RT;
        ctrl.wr       = 1'b1;
        ctrl.uses_rs  = 1'b1;
      end
      OP_LUI: begin
        ctrl.op       = ALU_LUI;
        ctrl.imm_sel  = IMM_LUI;
        ctrl.dest_sel = DEST_RT;
        ctrl.wr       = 1'b1;
      end
      OP_LW: begin
        ctrl.op       = ALU_ADD;
        ctrl.imm_sel  = IMM_SIGN;
        ctrl.dest_sel = DEST_RT;
        ctrl.wr       = 1'b1;
        ctrl.load     = 1'b1;
        ctrl.uses_rs  = 1'b1;
      end
      OP_SW: begin
        ctrl.op      = ALU_ADD;
        ctrl.imm_sel = IMM_SIGN;
        ctrl.store   = 1'b1;
        ctrl.uses_rs = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.op        = ALU_SUB;
        ctrl.imm_sel   = IMM_SIGN;
        ctrl.uses_rs   = 1'b1;
        ctrl.uses_rt   = 1'b1;
        ctrl.is_branch = 1'b1;
      end
      OP_JAL: begin
        ctrl.op       = ALU_LINK;
        ctrl.imm_sel  = IMM_LINK;
        ctrl.dest_sel = DEST_RA;
        ctrl.wr       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: IF/ID register, operand forwarding, hazard detection and the ID/EX register.
// Branch operands are resolved here, so branches need results one stage earlier than ALU ops.
module decode_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ex_wr,
  input  logic        mem_wr,
  input  logic        wb_wr,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_load,
  input  logic        mem_load,
  input  logic [31:0] ex_res,
  input  logic [31:0] mem_res,
  input  logic [31:0] wb_res,
  output logic [31:0] prev,
  output logic [31:0] prev_pc,
  output logic        eq,
  output logic [31:0] vs,
  output logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_a,
  output logic [31:0] id_b,
  output logic [31:0] id_imm,
  output alu_op_t     id_op,
  output logic [4:0]  id_dest,
  output logic        id_wr,
  output logic        id_load,
  output logic        id_store
);

  logic [31:0] ifid_pc, ifid_instr;
  logic [31:0] fwd_rs, fwd_rt, imm;
  logic [4:0]  rd, dest;
  logic [15:0] imm16;
  logic        load_use, branch_hazard;
  ctrl_t       ctrl;

  assign rs_addr = ifid_instr[25:21];
  assign rt_addr = ifid_instr[20:16];
  assign rd      = ifid_instr[15:11];
  assign imm16   = ifid_instr[15:0];

  decode_ctrl u_ctrl (
    .opcode (ifid_instr[31:26]),
    .funct  (ifid_instr[5:0]),
    .ctrl   (ctrl)
  );

  // Loads in EX/MEM have no data yet, so they are skipped here and covered by stalls.
  function automatic logic [31:0] forward(input logic [4:0] r, input logic [31:0] file_data);
    if (r == 5'd0)                             return 32'd0;
    else if (ex_wr && ex_rd == r && !ex_load)  return ex_res;
    else if (mem_wr && mem_rd == r && !mem_load) return mem_res;
    else if (wb_wr && wb_rd == r)              return wb_res;
    else                                       return file_data;
  endfunction

  function automatic logic hit(input logic [4:0] r, input logic writer, input logic [4:0] dst);
    return (r != 5'd0) && writer && (dst == r);
  endfunction

  assign fwd_rs = forward(rs_addr, rs_data);
  assign fwd_rt = forward(rt_addr, rt_data);

  assign load_use = (ctrl.uses_rs && hit(rs_addr, ex_wr && ex_load, ex_rd)) ||
                    (ctrl.uses_rt && hit(rt_addr, ex_wr && ex_load, ex_rd));
  assign branch_hazard = ctrl.is_branch &&
    ((ctrl.uses_rs && (hit(rs_addr, ex_wr, ex_rd) || hit(rs_addr, mem_wr && mem_load, mem_rd))) ||
     (ctrl.uses_rt && (hit(rt_addr, ex_wr, ex_rd) || hit(rt_addr, mem_wr && mem_load, mem_rd))));
  assign stall = load_use || branch_hazard;

  assign prev    = stall ? 32'd0 : ifid_instr;
  assign prev_pc = ifid_pc;
  assign eq      = (fwd_rs == fwd_rt);
  assign vs      = fwd_rs;

  always_comb begin
    case (ctrl.imm_sel)
      IMM_SIGN:  imm = {{16{imm16[15]}}, imm16};
      IMM_ZERO:  imm = {16'd0, imm16};
      IMM_LUI:   imm = {imm16, 16'd0};
      IMM_SHAMT: imm = {27'd0, ifid_instr[10:6]};
      IMM_LINK:  imm = ifid_pc + 32'd8;
      default:   imm = 32'd0;
    endcase
  end

  always_comb begin
    case (ctrl.dest_sel)
      DEST_RD: dest = rd;
      DEST_RT: dest = rt_addr;
      DEST_RA: dest = REG_RA;
      default: dest = 5'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_pc    <= 32'd0;
      ifid_instr <= 32'd0;
    end else if (!stall) begin
      ifid_pc    <= pc_in;
      ifid_instr <= instr_in;
    end
  end

  // A stall injects a fully cleared bubble while IF/ID holds the waiting instruction.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      id_valid <= 1'b0;
      id_pc    <= 32'd0;
      id_a     <= 32'd0;
      id_b     <= 32'd0;
      id_imm   <= 32'd0;
      id_op    <= ALU_NOP;
      id_dest  <= 5'd0;
      id_wr    <= 1'b0;
      id_load  <= 1'b0;
      id_store <= 1'b0;
    end else begin
      id_valid <= (ifid_instr != 32'd0);
      id_pc    <= ifid_pc;
      id_a     <= fwd_rs;
      id_b     <= fwd_rt;
      id_imm   <= imm;
      id_op    <= ctrl.op;
      id_dest  <= dest;
      id_wr    <= ctrl.wr && (dest != 5'd0);
      id_load  <= ctrl.load;
      id_store <= ctrl.store;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed pipeline scenarios followed by
// randomized instructions and bypass traffic against an instruction-level reference model.
module tb_decode_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, instr_in;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        ex_wr, mem_wr, wb_wr, ex_load, mem_load;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [31:0] ex_res, mem_res, wb_res;
  logic [31:0] prev, prev_pc, vs;
  logic        eq, stall;
  logic        id_valid, id_wr, id_load, id_store;
  logic [31:0] id_pc, id_a, id_b, id_imm;
  alu_op_t     id_op;
  logic [4:0]  id_dest;

  logic [31:0] regs [32];

  always #5 clk = ~clk;

  assign rs_data = regs[rs_addr];
  assign rt_data = regs[rt_addr];

  decode_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_load(ex_load), .mem_load(mem_load),
    .ex_res(ex_res), .mem_res(mem_res), .wb_res(wb_res),
    .prev(prev), .prev_pc(prev_pc), .eq(eq), .vs(vs), .stall(stall),
    .id_valid(id_valid), .id_pc(id_pc), .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
    .id_op(id_op), .id_dest(id_dest), .id_wr(id_wr), .id_load(id_load), .id_store(id_store)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, a, b, imm;
    alu_op_t     op;
    logic [4:0]  dest;
    logic        wr, load, store, has_imm;
  } idex_t;

  typedef struct packed {
    logic        rs_read, rt_read, branch, writes, load, store, has_imm;
    logic [4:0]  dest;
    logic [31:0] imm;
    alu_op_t     op;
  } dec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ifid_pc, m_ifid_instr, nxt_pc, nxt_instr;
  idex_t       m_idex, nxt_idex;

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // Instruction-level meaning of each supported mnemonic.
  function automatic dec_t m_decode(input logic [31:0] instr, input logic [31:0] pc);
    dec_t d;
    logic [5:0]  opc  = instr[31:26];
    logic [5:0]  fn   = instr[5:0];
    logic [15:0] im   = instr[15:0];
    logic [31:0] sext = {{16{im[15]}}, im};
    logic [31:0] zext = {16'd0, im};
    d = '0;
    d.op = ALU_NOP;
    if (opc == 6'd0) begin
      if (fn == 6'd0 || fn == 6'd2) begin
        d.op = (fn == 6'd0) ? ALU_SLL : ALU_SRL;
        d.rt_read = 1; d.writes = 1; d.dest = instr[15:11];
        d.has_imm = 1; d.imm = 32'(instr[10:6]);
      end else if (fn == 6'd8) begin
        d.rs_read = 1; d.branch = 1;
      end else if (fn == 6'd33 || fn == 6'd35 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42) begin
        d.op = (fn == 6'd33) ? ALU_ADD : (fn == 6'd35) ? ALU_SUB :
               (fn == 6'd36) ? ALU_AND : (fn == 6'd37) ? ALU_OR : ALU_SLT;
        d.rs_read = 1; d.rt_read = 1; d.writes = 1; d.dest = instr[15:11];
      end
    end else begin
      case (opc)
        6'd9:  begin d.op = ALU_ADD; d.rs_read = 1; d.writes = 1; d.dest = instr[20:16]; d.has_imm = 1; d.imm = sext; end
        6'd10: begin d.op = ALU_SLT; d.rs_read = 1; d.writes = 1; d.dest = instr[20:16]; d.has_imm = 1; d.imm = sext; end
        6'd12: begin d.op = ALU_AND; d.rs_read = 1; d.writes = 1; d.dest = instr[20:16]; d.has_imm = 1; d.imm = zext; end
        6'd13: begin d.op = ALU_OR;  d.rs_read = 1; d.writes = 1; d.dest = instr[20:16]; d.has_imm = 1; d.imm = zext; end
        6'd15: begin d.op = ALU_LUI; d.writes = 1; d.dest = instr[20:16]; d.has_imm = 1; d.imm = zext * 32'd65536; end
        6'd35: begin d.op = ALU_ADD; d.rs_read = 1; d.writes = 1; d.load = 1; d.dest = instr[20:16]; d.has_imm = 1; d.imm = sext; end
        6'd43: begin d.op = ALU_ADD; d.rs_read = 1; d.rt_read = 1; d.store = 1; d.has_imm = 1; d.imm = sext; end
        6'd4, 6'd5: begin d.op = ALU_SUB; d.rs_read = 1; d.rt_read = 1; d.branch = 1; d.has_imm = 1; d.imm = sext; end
        6'd3:  begin d.op = ALU_LINK; d.writes = 1; d.dest = 5'd31; d.has_imm = 1; d.imm = pc + 32'd8; end
        default: ;
      endcase
    end
    return d;
  endfunction

  function automatic logic [31:0] m_value(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (ex_wr && ex_rd == r && !ex_load) return ex_res;
    if (mem_wr && mem_rd == r && !mem_load) return mem_res;
    if (wb_wr && wb_rd == r) return wb_res;
    return regs[r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clearBypass();
    ex_wr = 0; mem_wr = 0; wb_wr = 0; ex_load = 0; mem_load = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_res = 0; mem_res = 0; wb_res = 0;
  endtask

  task automatic randomBypass();
    ex_wr = 1'($urandom);   ex_rd = ex_wr ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
    ex_load = ex_wr & 1'($urandom);
    mem_wr = 1'($urandom);  mem_rd = mem_wr ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
    mem_load = mem_wr & 1'($urandom);
    wb_wr = 1'($urandom);   wb_rd = wb_wr ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
    ex_res = $urandom; mem_res = $urandom; wb_res = $urandom;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr);
    pc_in = pc;
    instr_in = instr;
  endtask

  // Compares every output against the model, then prepares the model's next state.
  task automatic checkOutput();
    dec_t        d;
    logic [4:0]  rs, rt;
    logic [31:0] fa, fb;
    logic [4:0]  reads[$];
    logic        exp_stall;
    #1;
    d  = m_decode(m_ifid_instr, m_ifid_pc);
    rs = m_ifid_instr[25:21];
    rt = m_ifid_instr[20:16];
    fa = m_value(rs);
    fb = m_value(rt);
    if (d.rs_read) reads.push_back(rs);
    if (d.rt_read) reads.push_back(rt);
    exp_stall = 0;
    foreach (reads[i]) begin
      if (reads[i] != 0) begin
        if (ex_wr && ex_load && ex_rd == reads[i]) exp_stall = 1;
        if (d.branch && ((ex_wr && ex_rd == reads[i]) ||
                         (mem_wr && mem_load && mem_rd == reads[i]))) exp_stall = 1;
      end
    end
    chk("rs_addr", 32'(rs_addr), 32'(rs));
    chk("rt_addr", 32'(rt_addr), 32'(rt));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("prev", prev, exp_stall ? 32'd0 : m_ifid_instr);
    chk("prev_pc", prev_pc, m_ifid_pc);
    chk("eq", 32'(eq), 32'(fa == fb));
    chk("vs", vs, fa);
    chk("id_valid", 32'(id_valid), 32'(m_idex.valid));
    chk("id_wr", 32'(id_wr), 32'(m_idex.wr));
    chk("id_load", 32'(id_load), 32'(m_idex.load));
    chk("id_store", 32'(id_store), 32'(m_idex.store));
    if (m_idex.valid) begin
      chk("id_pc", id_pc, m_idex.pc);
      chk("id_a", id_a, m_idex.a);
      chk("id_b", id_b, m_idex.b);
      chk("id_op", 32'(id_op), 32'(m_idex.op));
      if (m_idex.has_imm) chk("id_imm", id_imm, m_idex.imm);
      if (m_idex.wr) chk("id_dest", 32'(id_dest), 32'(m_idex.dest));
    end
    nxt_pc = m_ifid_pc;
    nxt_instr = m_ifid_instr;
    nxt_idex = '0;
    if (!exp_stall) begin
      nxt_pc = pc_in;
      nxt_instr = instr_in;
      nxt_idex.valid   = (m_ifid_instr != 0);
      nxt_idex.pc      = m_ifid_pc;
      nxt_idex.a       = fa;
      nxt_idex.b       = fb;
      nxt_idex.imm     = d.imm;
      nxt_idex.op      = d.op;
      nxt_idex.dest    = d.dest;
      nxt_idex.wr      = d.writes && d.dest != 0;
      nxt_idex.load    = d.load;
      nxt_idex.store   = d.store;
      nxt_idex.has_imm = d.has_imm;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_ifid_pc = 0; m_ifid_instr = 0; m_idex = '0;
    end else begin
      m_ifid_pc = nxt_pc; m_ifid_instr = nxt_instr; m_idex = nxt_idex;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] genInstr();
    logic [4:0]  a  = 5'($urandom_range(0, 7));
    logic [4:0]  b  = 5'($urandom_range(0, 7));
    logic [4:0]  c  = 5'($urandom_range(0, 7));
    logic [4:0]  sh = 5'($urandom);
    logic [15:0] im = 16'($urandom);
    case ($urandom_range(0, 20))
      0:  return mk_r(a, b, c, 0, 6'd33);
      1:  return mk_r(a, b, c, 0, 6'd35);
      2:  return mk_r(a, b, c, 0, 6'd36);
      3:  return mk_r(a, b, c, 0, 6'd37);
      4:  return mk_r(a, b, c, 0, 6'd42);
      5:  return mk_r(0, b, c, sh, 6'd0);
      6:  return mk_r(0, b, c, sh, 6'd2);
      7:  return mk_r(a, 0, 0, 0, 6'd8);
      8:  return mk_i(6'd9, a, b, im);
      9:  return mk_i(6'd10, a, b, im);
      10: return mk_i(6'd12, a, b, im);
      11: return mk_i(6'd13, a, b, im);
      12: return mk_i(6'd15, 0, b, im);
      13: return mk_i(6'd35, a, b, im);
      14: return mk_i(6'd43, a, b, im);
      15: return mk_i(6'd4, a, b, im);
      16: return mk_i(6'd5, a, b, im);
      17: return mk_j(6'd2, 26'($urandom));
      18: return mk_j(6'd3, 26'($urandom));
      19: return mk_i(6'h3f, a, b, im);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] beq45, jr6;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    m_ifid_pc = 0; m_ifid_instr = 0; m_idex = '0;
    nxt_pc = 0; nxt_instr = 0; nxt_idex = '0;
    reset = 1;
    clearBypass();
    applyStimulus(0, 0);
    @(negedge clk);
    tick();
    tick();
    reset = 0;

    checkOutput();
    chk("reset_eq", 32'(eq), 1);
    chk("reset_valid", 32'(id_valid), 0);
    tick();

    applyStimulus(32'h0, mk_i(6'd9, 0, 1, 16'd5));
    checkOutput(); tick();
    applyStimulus(32'h4, 0);
    checkOutput(); tick();
    applyStimulus(32'h8, 0);
    checkOutput();
    chk("addiu_valid", 32'(id_valid), 1);
    chk("addiu_imm", id_imm, 5);
    chk("addiu_dest", 32'(id_dest), 1);
    chk("addiu_wr", 32'(id_wr), 1);
    tick();

    applyStimulus(32'hC, mk_i(6'd35, 1, 2, 16'd0));
    checkOutput(); tick();
    applyStimulus(32'h10, mk_r(2, 2, 3, 0, 6'd33));
    checkOutput(); tick();
    ex_wr = 1; ex_rd = 2; ex_load = 1; ex_res = 32'hDEAD_0000;
    applyStimulus(32'h14, 0);
    checkOutput();
    chk("lu_stall_on", 32'(stall), 1);
    tick();
    clearBypass();
    wb_wr = 1; wb_rd = 2; wb_res = 32'h1234_5678;
    checkOutput();
    chk("lu_stall_off", 32'(stall), 0);
    chk("lu_bubble", 32'(id_valid), 0);
    tick();
    clearBypass();
    applyStimulus(32'h18, 0);
    checkOutput();
    chk("lu_addu_a", id_a, 32'h1234_5678);
    chk("lu_addu_pc", id_pc, 32'h10);
    tick();

    beq45 = mk_i(6'd4, 4, 5, 16'd3);
    regs[5] = 7; regs[4] = 99;
    applyStimulus(32'h1C, beq45);
    checkOutput(); tick();
    ex_wr = 1; ex_rd = 4; ex_res = 7;
    applyStimulus(32'h20, 0);
    checkOutput();
    chk("br_alu_stall", 32'(stall), 1);
    chk("br_alu_prev0", prev, 0);
    tick();
    clearBypass();
    mem_wr = 1; mem_rd = 4; mem_res = 7;
    checkOutput();
    chk("br_alu_go", 32'(stall), 0);
    chk("br_alu_eq", 32'(eq), 1);
    chk("br_alu_prev", prev, beq45);
    tick();

    jr6 = mk_r(6, 0, 0, 0, 6'd8);
    clearBypass();
    applyStimulus(32'h24, jr6);
    checkOutput(); tick();
    ex_wr = 1; ex_rd = 6; ex_load = 1;
    applyStimulus(32'h28, 0);
    checkOutput();
    chk("jr_stall1", 32'(stall), 1);
    chk("jr_prev1", prev, 0);
    tick();
    clearBypass();
    mem_wr = 1; mem_rd = 6; mem_load = 1; mem_res = 32'hBAD0_BAD0;
    checkOutput();
    chk("jr_stall2", 32'(stall), 1);
    chk("jr_prev2", prev, 0);
    tick();
    clearBypass();
    wb_wr = 1; wb_rd = 6; wb_res = 32'hCAFE_0040;
    checkOutput();
    chk("jr_go", 32'(stall), 0);
    chk("jr_vs", vs, 32'hCAFE_0040);
    chk("jr_prev", prev, jr6);
    tick();

    clearBypass();
    applyStimulus(32'h40, mk_j(6'd3, 26'h100));
    checkOutput(); tick();
    applyStimulus(32'h44, mk_i(6'd43, 1, 3, 16'd4));
    checkOutput(); tick();
    applyStimulus(32'h48, 0);
    checkOutput();
    chk("jal_imm", id_imm, 32'h48);
    chk("jal_dest", 32'(id_dest), 31);
    chk("jal_wr", 32'(id_wr), 1);
    tick();
    applyStimulus(32'h4C, 0);
    checkOutput();
    chk("sw_wr", 32'(id_wr), 0);
    chk("sw_store", 32'(id_store), 1);
    tick();

    applyStimulus(32'h50, jr6);
    checkOutput(); tick();
    ex_wr = 1; ex_rd = 6; ex_load = 1;
    applyStimulus(32'h54, 0);
    checkOutput(); tick();
    clearBypass();
    mem_wr = 1; mem_rd = 6; mem_load = 1;
    reset = 1;
    checkOutput();
    chk("rst_stall_pre", 32'(stall), 1);
    tick();
    reset = 0;
    clearBypass();
    checkOutput();
    chk("rst_stall_post", 32'(stall), 0);
    chk("rst_valid_post", 32'(id_valid), 0);
    tick();

    for (int n = 0; n < 400; n++) begin
      randomBypass();
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 31)] = $urandom;
      reset = ($urandom_range(0, 63) == 0);
      applyStimulus({$urandom_range(0, 32'h3FFF), 2'b00}, genInstr());
      checkOutput();
      tick();
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
